osim_probe: RTL and testbench

- Wishbone classic single-transfer master that sits directly upstream of the system-info register slave (5-bit word-aligned address space: FREQ, UART_BASE, UART_IRQ, DRAM_BASE, DRAM_SIZE).
- After reset, or on request, it reads all five registers in order and holds them as static outputs for the rest of the SoC (UART divisor logic, IRQ routing, DRAM controller).
- Handles slave retry, error and silence (timeout), and reports which register failed.

---
 rtl/osim_probe.sv | 195 +++++++++++++++++++
 tb/tb_osim_probe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osim_probe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// osim_probe : Wishbone classic master that reads the five system-info
//              registers after reset or on request. Rev 1.0
// ---------------------------------------------------------------------------
module osim_probe #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  adr_o,
    output logic [31:0] dat_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    input  logic        rty_i,
    input  logic        err_i,
    input  logic [31:0] dat_i,
    output logic [31:0] freq,
    output logic [31:0] uart_base,
    output logic [31:0] uart_irq,
    output logic [31:0] dram_base,
    output logic [31:0] dram_size,
    output logic        valid,
    output logic        busy,
    output logic        error,
    output logic [2:0]  err_idx,
    output logic [1:0]  err_cause
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] C_CAUSE_NONE = 2'd0;
    localparam logic [1:0] C_CAUSE_ERR  = 2'd1;
    localparam logic [1:0] C_CAUSE_RTY  = 2'd2;
    localparam logic [1:0] C_CAUSE_TMO  = 2'd3;
    localparam logic [2:0] C_LAST_IDX   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;
    logic [2:0]      err_idx_q, err_idx_d;
    logic [1:0]      cause_q, cause_d;
    logic            load;
    logic [31:0]     freq_q, uart_base_q, uart_irq_q, dram_base_q, dram_size_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            retry_q   <= '0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= 3'd0;
            cause_q   <= C_CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        valid_d   = valid_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        cause_d   = cause_q;
        load      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                idx_d   = 3'd0;
                retry_d = '0;
                tmo_d   = '0;
            end
            S_REQ: begin
                tmo_d = tmo_q + 1'b1;
                // Response priority: err over ack over rty, then timeout.
                if (err_i) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b0;
                    error_d   = 1'b1;
                    err_idx_d = idx_q;
                    cause_d   = C_CAUSE_ERR;
                end else if (ack_i) begin
                    load    = 1'b1;
                    retry_d = '0;
                    if (idx_q == C_LAST_IDX) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        error_d = 1'b0;
                        cause_d = C_CAUSE_NONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_GAP;
                    end
                end else if (rty_i) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        state_d   = S_DONE;
                        valid_d   = 1'b0;
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        cause_d   = C_CAUSE_RTY;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_GAP;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b0;
                    error_d   = 1'b1;
                    err_idx_d = idx_q;
                    cause_d   = C_CAUSE_TMO;
                end
            end
            // One idle bus cycle swallows a late ack from a registered slave.
            S_GAP: begin
                state_d = S_REQ;
                tmo_d   = '0;
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                    cause_d = C_CAUSE_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q      <= 32'd0;
            uart_base_q <= 32'd0;
            uart_irq_q  <= 32'd0;
            dram_base_q <= 32'd0;
            dram_size_q <= 32'd0;
        end else if (load) begin
            case (idx_q)
                3'd0:    freq_q      <= dat_i;
                3'd1:    uart_base_q <= dat_i;
                3'd2:    uart_irq_q  <= dat_i;
                3'd3:    dram_base_q <= dat_i;
                3'd4:    dram_size_q <= dat_i;
                default: ;
            endcase
        end
    end

    assign cyc_o     = (state_q == S_REQ);
    assign stb_o     = cyc_o;
    assign adr_o     = {idx_q, 2'b00};
    assign dat_o     = 32'd0;
    assign we_o      = 1'b0;
    assign sel_o     = 4'hf;
    assign busy      = (state_q != S_DONE);
    assign valid     = valid_q;
    assign error     = error_q;
    assign err_idx   = err_idx_q;
    assign err_cause = cause_q;
    assign freq      = freq_q;
    assign uart_base = uart_base_q;
    assign uart_irq  = uart_irq_q;
    assign dram_base = dram_base_q;
    assign dram_size = dram_size_q;

endmodule
`default_nettype wire

// File: tb/tb_osim_probe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_osim_probe : scoreboard bench for osim_probe with a registered slave model.
// ---------------------------------------------------------------------------
module tb_osim_probe;

    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  adr_o;
    logic [31:0] dat_o;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic        ack_i, rty_i, err_i;
    logic [31:0] dat_i;
    logic [31:0] freq, uart_base, uart_irq, dram_base, dram_size;
    logic        valid, busy, error;
    logic [2:0]  err_idx;
    logic [1:0]  err_cause;

    always #5 clk = ~clk;

    osim_probe #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .start(start),
        .adr_o(adr_o), .dat_o(dat_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .we_o(we_o), .sel_o(sel_o),
        .ack_i(ack_i), .rty_i(rty_i), .err_i(err_i), .dat_i(dat_i),
        .freq(freq), .uart_base(uart_base), .uart_irq(uart_irq),
        .dram_base(dram_base), .dram_size(dram_size),
        .valid(valid), .busy(busy), .error(error),
        .err_idx(err_idx), .err_cause(err_cause)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Slave plan: mode 0 = ack (after nrty retries), 1 = err, 2 = silent.
    int          mode [5];
    int          nrty [5];
    logic [31:0] pdata [5];
    int          gen = 0;

    // Registered slave: samples the strobe mid-cycle, answers in the next cycle.
    initial begin
        int          used [5];
        int          my_gen;
        int          nxt;
        int          i;
        logic [31:0] nd;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 32'd0;
        my_gen = -1;
        forever begin
            @(negedge clk);
            if (my_gen != gen) begin
                for (int k = 0; k < 5; k++) used[k] = 0;
                my_gen = gen;
            end
            nxt = 0;
            nd  = 32'hDEADBEEF;
            if (cyc_o && stb_o && !ack_i && !err_i && !rty_i) begin
                i = int'(adr_o[4:2]);
                if (i < 5) begin
                    if (mode[i] == 1) nxt = 2;
                    else if (mode[i] == 0) begin
                        if (used[i] < nrty[i]) begin
                            used[i]++;
                            nxt = 3;
                        end else begin
                            nxt = 1;
                            nd  = pdata[i];
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            ack_i = (nxt == 1);
            err_i = (nxt == 2);
            rty_i = (nxt == 3);
            dat_i = nd;
        end
    end

    // Bus monitor: strobe starts, their addresses, and cycles with cyc_o high.
    int         stb_tot = 0;
    int         cyc_tot = 0;
    int         stb_bad = 0;
    logic       prev_cyc = 1'b0;
    logic [4:0] seen_adr [256];

    always @(negedge clk) begin
        prev_cyc <= cyc_o;
        if (stb_o !== cyc_o) stb_bad <= stb_bad + 1;
        if (cyc_o) begin
            cyc_tot <= cyc_tot + 1;
            if (!prev_cyc) begin
                seen_adr[stb_tot % 256] <= adr_o;
                stb_tot <= stb_tot + 1;
            end
        end
    end

    typedef struct {
        logic [4:0][31:0] r;
        logic             v;
        logic             e;
        int               eidx;
        int               cause;
        int               cyc;
        int               nstb;
    } res_t;

    res_t             exp_q [$];
    int               exp_adr [$];
    logic [4:0][31:0] exp_regs = '0;
    int               last_eidx = 0;

    task automatic plan(input int err_at, input int sil_at, input int rty_at, input int rty_n);
        for (int k = 0; k < 5; k++) begin
            mode[k]  = (k == err_at) ? 1 : (k == sil_at) ? 2 : 0;
            nrty[k]  = (k == rty_at) ? rty_n : 0;
            pdata[k] = $urandom;
        end
        gen++;
    endtask

    // Expected outcome of one probe, derived from the slave plan.
    task automatic model();
        res_t r;
        int   done;
        r.r = exp_regs; r.v = 1'b0; r.e = 1'b0; r.eidx = last_eidx;
        r.cause = 0; r.cyc = 0; r.nstb = 0; done = 0;
        for (int i = 0; i < 5 && done == 0; i++) begin
            if (mode[i] != 0) begin
                exp_adr.push_back(i * 4);
                r.nstb++;
                r.cyc  += (mode[i] == 1) ? 2 : TIMEOUT;
                r.e     = 1'b1;
                r.eidx  = i;
                r.cause = (mode[i] == 1) ? 1 : 3;
                done    = 1;
            end else begin
                for (int k = 0; k < nrty[i] && done == 0; k++) begin
                    exp_adr.push_back(i * 4);
                    r.nstb++;
                    r.cyc += 2;
                    if (k == MAX_RETRY) begin
                        r.e = 1'b1; r.eidx = i; r.cause = 2; done = 1;
                    end
                end
                if (done == 0) begin
                    exp_adr.push_back(i * 4);
                    r.nstb++;
                    r.cyc += 2;
                    r.r[i] = pdata[i];
                end
            end
        end
        r.v       = !r.e;
        exp_regs  = r.r;
        last_eidx = r.eidx;
        exp_q.push_back(r);
    endtask

    task automatic compare(input int s0, input int c0);
        res_t r;
        r = exp_q.pop_front();
        check("freq",      freq,      r.r[0]);
        check("uart_base", uart_base, r.r[1]);
        check("uart_irq",  uart_irq,  r.r[2]);
        check("dram_base", dram_base, r.r[3]);
        check("dram_size", dram_size, r.r[4]);
        check("valid",     32'(valid),     32'(r.v));
        check("error",     32'(error),     32'(r.e));
        check("err_idx",   32'(err_idx),   32'(r.eidx));
        check("err_cause", 32'(err_cause), 32'(r.cause));
        check("cyc_idle",  32'(cyc_o),     32'd0);
        check("cyc_cycles", 32'(cyc_tot - c0), 32'(r.cyc));
        check("strobes",   32'(stb_tot - s0), 32'(r.nstb));
        check("stb_eq_cyc", 32'(stb_bad), 32'd0);
        for (int k = 0; k < r.nstb; k++)
            check("adr", 32'(seen_adr[(s0 + k) % 256]), 32'(exp_adr.pop_front()));
        exp_adr.delete();
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        if (busy) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic probe();
        int s0, c0;
        s0 = stb_tot; c0 = cyc_tot;
        model();
        pulse_start();
        check("valid_drop", 32'(valid), 32'd0);
        check("busy_rise",  32'(busy),  32'd1);
        wait_done();
        compare(s0, c0);
    endtask

    task automatic timed_15(input string tag);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 14) check({tag, "_valid14"}, 32'(valid), 32'd0);
            if (k == 15) begin
                check({tag, "_valid15"}, 32'(valid), 32'd1);
                check({tag, "_busy15"},  32'(busy),  32'd0);
            end
        end
    endtask

    initial begin
        int s0, c0, n;

        // Reset state and the automatic first probe with the reference values.
        plan(-1, -1, -1, 0);
        pdata[0] = 32'h02FAF080; pdata[1] = 32'h90000000; pdata[2] = 32'h2;
        pdata[3] = 32'h00000000; pdata[4] = 32'h08000000;
        repeat (3) @(negedge clk);
        check("rst_cyc",   32'(cyc_o),     32'd0);
        check("rst_busy",  32'(busy),      32'd1);
        check("rst_valid", 32'(valid),     32'd0);
        check("rst_error", 32'(error),     32'd0);
        check("rst_cause", 32'(err_cause), 32'd0);
        check("rst_freq",  freq,           32'd0);
        s0 = stb_tot; c0 = cyc_tot;
        model();
        rst = 1'b0;
        timed_15("boot");
        compare(s0, c0);

        // Slave error on uart_irq.
        plan(2, -1, -1, 0);
        probe();

        // Two retries on uart_base, with start pulses ignored mid-probe.
        plan(-1, -1, 1, 2);
        s0 = stb_tot; c0 = cyc_tot;
        model();
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();
        compare(s0, c0);
        repeat (6) @(negedge clk);
        check("no_queued", 32'(busy), 32'd0);

        // Retry limit exceeded on freq.
        plan(-1, -1, 0, 4);
        probe();

        // Silent slave.
        plan(-1, 0, -1, 0);
        probe();

        // Clean re-probe latency.
        plan(-1, -1, -1, 0);
        s0 = stb_tot; c0 = cyc_tot;
        model();
        pulse_start();
        check("re_valid_drop", 32'(valid), 32'd0);
        timed_15("reprobe");
        compare(s0, c0);

        // Reset while requesting dram_base.
        plan(-1, -1, -1, 0);
        pulse_start();
        n = 0;
        while (!(cyc_o && adr_o == 5'd12) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx3", 32'(cyc_o && adr_o == 5'd12), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cyc",   32'(cyc_o),   32'd0);
        check("mid_rst_busy",  32'(busy),    32'd1);
        check("mid_rst_valid", 32'(valid),   32'd0);
        check("mid_rst_freq",  freq,         32'd0);
        check("mid_rst_dsize", dram_size,    32'd0);
        check("mid_rst_eidx",  32'(err_idx), 32'd0);
        exp_regs  = '0;
        last_eidx = 0;
        s0 = stb_tot; c0 = cyc_tot;
        model();
        rst = 1'b0;
        wait_done();
        compare(s0, c0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
